// File: rtl/vfilter_pkg.sv
// Shared state encoding, tap ordering and coefficient scale for the vertical-filter control path.
package vfilter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    PRIME    = 3'd2,
    RUN      = 3'd3,
    FLUSH    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Lane order inside the packed tap bus handed to the filter.
  localparam int TAP_ABOVE  = 0;
  localparam int TAP_CENTRE = 1;
  localparam int TAP_BELOW  = 2;

  localparam int DEF_COEFF_WIDTH = 14;
  localparam int COEFF_ONE       = 1 << (DEF_COEFF_WIDTH - 2);

endpackage

// File: rtl/vfilter_line_buf.sv
// One-line pixel store: simple dual-port RAM with a registered read port.
// A read and write to the same address in one cycle returns the old contents.
module vfilter_line_buf #(
  parameter int DEPTH = 1920,
  parameter int WIDTH = 8,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vfilter_ctrl.sv
// Frame sequencer and line-buffer front end for the 3-tap vertical filter.
// Define VFILTER_CTRL_EDGE_ZERO_EN to drive rows outside the frame as 0 instead of replicating the edge row.
module vfilter_ctrl
  import vfilter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 14,
  parameter int MAX_W       = 1920,
  parameter int MAX_H       = 1080,
  parameter int FILT_LAT    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(MAX_W+1)-1:0] cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0] cfg_height,
  input  logic [COEFF_WIDTH-1:0]     cfg_coeff0,
  input  logic [COEFF_WIDTH-1:0]     cfg_coeff1,
  input  logic [COEFF_WIDTH-1:0]     cfg_coeff2,
  input  logic                       cfg_start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_sof,
  input  logic                       s_eol,
  output logic                       f_valid,
  output logic [3*DATA_WIDTH-1:0]    f_taps,
  output logic [COEFF_WIDTH-1:0]     f_coeff0,
  output logic [COEFF_WIDTH-1:0]     f_coeff1,
  output logic [COEFF_WIDTH-1:0]     f_coeff2,
  input  logic                       f_res_valid,
  input  logic [DATA_WIDTH-1:0]      f_res_data,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_sof,
  output logic                       m_eol,
  output logic                       busy,
  output logic                       err
);

  localparam int CW  = $clog2(MAX_W + 1);
  localparam int HW  = $clog2(MAX_H + 1);
  localparam int AW  = $clog2(MAX_W);
  localparam int DRW = $clog2(FILT_LAT + 1);

  state_e                  state;
  logic [CW-1:0]           width_sh, col, width_m1;
  logic [HW-1:0]           height_sh, row, height_m1;
  logic [COEFF_WIDTH-1:0]  coeff0_sh, coeff1_sh, coeff2_sh;
  logic [DRW-1:0]          drain;
  logic                    sel, sel_q;
  logic                    above_edge_q, below_edge_q, f_sof_q, f_eol_q;
  logic [DATA_WIDTH-1:0]   pix_q, rd0, rd1, centre, older, above, below, edge_row;
  logic [FILT_LAT-1:0]     sof_sr, eol_sr;
  logic                    accept, col_last, frame_beat, run_beat;

  assign width_m1   = width_sh - CW'(1);
  assign height_m1  = height_sh - HW'(1);
  assign accept     = s_valid & s_ready;
  assign col_last   = (col == width_m1);
  assign frame_beat = accept & ((state == PRIME) | (state == RUN) | ((state == WAIT_SOF) & s_sof));
  assign run_beat   = accept & (state == RUN);

  // sel picks which physical RAM holds the newest complete row; the other one takes the incoming row.
  vfilter_line_buf #(.DEPTH(MAX_W), .WIDTH(DATA_WIDTH), .AW(AW)) u_lb0 (
    .clk(clk), .we(frame_beat & sel), .waddr(col[AW-1:0]), .wdata(s_data),
    .raddr(col[AW-1:0]), .rdata(rd0)
  );

  vfilter_line_buf #(.DEPTH(MAX_W), .WIDTH(DATA_WIDTH), .AW(AW)) u_lb1 (
    .clk(clk), .we(frame_beat & ~sel), .waddr(col[AW-1:0]), .wdata(s_data),
    .raddr(col[AW-1:0]), .rdata(rd1)
  );

  assign centre = sel_q ? rd1 : rd0;
  assign older  = sel_q ? rd0 : rd1;

`ifdef VFILTER_CTRL_EDGE_ZERO_EN
  assign edge_row = '0;
`else
  assign edge_row = centre;
`endif

  assign above = above_edge_q ? edge_row : older;
  assign below = below_edge_q ? edge_row : pix_q;

  always_comb begin
    f_taps = '0;
    if (f_valid) begin
      f_taps[TAP_ABOVE*DATA_WIDTH  +: DATA_WIDTH] = above;
      f_taps[TAP_CENTRE*DATA_WIDTH +: DATA_WIDTH] = centre;
      f_taps[TAP_BELOW*DATA_WIDTH  +: DATA_WIDTH] = below;
    end
  end

  assign f_coeff0 = coeff0_sh;
  assign f_coeff1 = coeff1_sh;
  assign f_coeff2 = coeff2_sh;

  // Gating by busy keeps stale filter results off the output stream after a reset or abandoned frame.
  assign m_valid = f_res_valid & busy;
  assign m_data  = m_valid ? f_res_data : '0;
  assign m_sof   = sof_sr[FILT_LAT-1];
  assign m_eol   = eol_sr[FILT_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      f_valid      <= 1'b0;
      width_sh     <= '0;
      height_sh    <= '0;
      coeff0_sh    <= '0;
      coeff1_sh    <= '0;
      coeff2_sh    <= '0;
      col          <= '0;
      row          <= '0;
      drain        <= '0;
      sel          <= 1'b0;
      sel_q        <= 1'b0;
      pix_q        <= '0;
      above_edge_q <= 1'b0;
      below_edge_q <= 1'b0;
      f_sof_q      <= 1'b0;
      f_eol_q      <= 1'b0;
      sof_sr       <= '0;
      eol_sr       <= '0;
    end else begin
      f_valid      <= run_beat | (state == FLUSH);
      pix_q        <= s_data;
      sel_q        <= sel;
      above_edge_q <= ((state == RUN) && (row == HW'(1))) || ((state == FLUSH) && (height_sh == HW'(1)));
      below_edge_q <= (state == FLUSH);
      f_sof_q      <= (col == '0) && (((state == RUN) && (row == HW'(1))) ||
                                      ((state == FLUSH) && (height_sh == HW'(1))));
      f_eol_q      <= col_last;
      sof_sr       <= {sof_sr[FILT_LAT-2:0], f_valid & f_sof_q};
      eol_sr       <= {eol_sr[FILT_LAT-2:0], f_valid & f_eol_q};

      if (accept && s_eol && !col_last) err <= 1'b1;
      if (accept && s_sof && ((state == PRIME) || (state == RUN))) err <= 1'b1;
      if (cfg_start && (state != IDLE)) err <= 1'b1;

      case (state)
        IDLE: if (cfg_start) begin
          width_sh  <= cfg_width;
          height_sh <= cfg_height;
          coeff0_sh <= cfg_coeff0;
          coeff1_sh <= cfg_coeff1;
          coeff2_sh <= cfg_coeff2;
          err       <= 1'b0;
          col       <= '0;
          row       <= '0;
          sel       <= 1'b0;
          s_ready   <= 1'b1;
          busy      <= 1'b1;
          state     <= WAIT_SOF;
        end
        WAIT_SOF, PRIME, RUN: begin
          if (accept && !frame_beat) err <= 1'b1;
          if (frame_beat) begin
            if (col_last) begin
              col <= '0;
              sel <= ~sel;
              if (row == height_m1) begin
                s_ready <= 1'b0;
                state   <= FLUSH;
              end else begin
                row   <= row + HW'(1);
                state <= RUN;
              end
            end else begin
              col <= col + CW'(1);
              if (state == WAIT_SOF) state <= PRIME;
            end
          end
        end
        FLUSH: if (col_last) begin
          col   <= '0;
          drain <= '0;
          state <= DONE;
        end else begin
          col <= col + CW'(1);
        end
        DONE: if (drain == DRW'(FILT_LAT)) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          drain <= drain + DRW'(1);
        end
        default: begin
          s_ready <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
